// File: rtl/rtc_core.sv
// Real-time clock core: 1 Hz prescaler, hh:mm:ss keeping and key-driven field adjustment.
// Optional calendar (month/day, carry, adjust, day clamp) compiled in with `RTC_DATE_EN`.
module rtc_core #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] model,
  input  logic [1:0] adjust_shif,
  input  logic       date_time_ch,
  input  logic       key_up,
  input  logic       key_down,
  output logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second
`ifdef RTC_DATE_EN
  ,
  output logic [3:0] month,
  output logic [4:0] day
`endif
);

  localparam int unsigned PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
  localparam logic [1:0] MODEL_ADJ = 2'b01;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          up_c, dn_c;
`ifdef RTC_DATE_EN
  logic [3:0]    mon_q, mon_d;
  logic [4:0]    day_q, day_d;

  function automatic logic [4:0] days_in_month(input logic [3:0] m);
    case (m)
      4'd2:                      days_in_month = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   days_in_month = 5'd30;
      default:                   days_in_month = 5'd31;
    endcase
  endfunction
`endif

  // +1/-1 with wrap inside [lo, hi]; simultaneous up/down is filtered by the caller
  function automatic logic [5:0] wrap_adj(input logic [5:0] v, input logic [5:0] lo,
                                          input logic [5:0] hi, input logic up,
                                          input logic dn);
    if (up)      wrap_adj = (v >= hi) ? lo : v + 6'd1;
    else if (dn) wrap_adj = (v <= lo) ? hi : v - 6'd1;
    else         wrap_adj = v;
  endfunction

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
`ifdef RTC_DATE_EN
    mon_d   = mon_q;
    day_d   = day_q;
`endif
    up_c    = key_up & ~key_down;
    dn_c    = key_down & ~key_up;

    if (model == MODEL_ADJ) begin
      // Adjust: prescaler parked at 0, no ticks, fields edited without carry
      presc_d = '0;
      if (!date_time_ch) begin
        case (adjust_shif)
          2'b00:   sec_d  = wrap_adj(sec_q, 6'd0, 6'd59, up_c, dn_c);
          2'b01:   min_d  = wrap_adj(min_q, 6'd0, 6'd59, up_c, dn_c);
          2'b10:   hour_d = 5'(wrap_adj(6'(hour_q), 6'd0, 6'd23, up_c, dn_c));
          default: ;
        endcase
      end
`ifdef RTC_DATE_EN
      else begin
        case (adjust_shif)
          2'b00:   day_d = 5'(wrap_adj(6'(day_q), 6'd1, 6'(days_in_month(mon_q)), up_c, dn_c));
          2'b01:   mon_d = 4'(wrap_adj(6'(mon_q), 6'd1, 6'd12, up_c, dn_c));
          default: ;
        endcase
      end
`endif
    end else begin
      if (presc_q == PRE_TC) begin
        presc_d = '0;
        // Second boundary: ripple carry through the time (and calendar) fields
        if (sec_q == 6'd59) begin
          sec_d = '0;
          if (min_q == 6'd59) begin
            min_d = '0;
            if (hour_q == 5'd23) begin
              hour_d = '0;
`ifdef RTC_DATE_EN
              if (day_q >= days_in_month(mon_q)) begin
                day_d = 5'd1;
                mon_d = (mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1;
              end else begin
                day_d = day_q + 5'd1;
              end
`endif
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
      tick_d = (presc_d == PRE_TC);
    end

`ifdef RTC_DATE_EN
    // Keep day legal after any month change
    if (day_d > days_in_month(mon_d)) day_d = days_in_month(mon_d);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
`ifdef RTC_DATE_EN
      mon_q   <= 4'd1;
      day_q   <= 5'd1;
`endif
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
`ifdef RTC_DATE_EN
      mon_q   <= mon_d;
      day_q   <= day_d;
`endif
    end
  end

  assign tick_1hz = tick_q;
  assign hour     = hour_q;
  assign minute   = min_q;
  assign second   = sec_q;
`ifdef RTC_DATE_EN
  assign month    = mon_q;
  assign day      = day_q;
`endif

endmodule

// File: tb/tb_rtc_core.sv
// Scoreboard bench for rtc_core: a time-of-day/calendar reference model predicts every cycle,
// a monitor compares DUT outputs one step behind the driver. Honours `RTC_DATE_EN`.
module tb_rtc_core;

  localparam int unsigned FREQ = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] model = 2'b00;
  logic [1:0] adjust_shif = 2'b00;
  logic       date_time_ch = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
`ifdef RTC_DATE_EN
  logic [3:0] month;
  logic [4:0] day;
`endif

  rtc_core #(.CLK_FREQ(FREQ)) dut (
    .clk(clk), .rst_n(rst_n), .model(model), .adjust_shif(adjust_shif),
    .date_time_ch(date_time_ch), .key_up(key_up), .key_down(key_down),
    .tick_1hz(tick_1hz), .hour(hour), .minute(minute), .second(second)
`ifdef RTC_DATE_EN
    , .month(month), .day(day)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    int h, m, s, mo, dy;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference state: run-cycle phase, seconds since midnight, calendar
  int phase = 0;
  int tod = 0;
  int mon = 1;
  int dy = 1;
  bit etick = 0;

  function automatic int dim(input int m);
    case (m)
      2: return 28;
      4, 6, 9, 11: return 30;
      default: return 31;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; tod = 0; mon = 1; dy = 1; etick = 0;
  endtask

  task automatic model_step(input logic [1:0] md, input logic [1:0] sh, input logic dtc,
                            input logic up, input logic dn);
    int h, m, s, d;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    if (md == 2'b01) begin
      phase = 0;
      etick = 0;
      if (up != dn) begin
        d = up ? 1 : -1;
        if (!dtc) begin
          if (sh == 2'd0) s = (s + d + 60) % 60;
          else if (sh == 2'd1) m = (m + d + 60) % 60;
          else if (sh == 2'd2) h = (h + d + 24) % 24;
          tod = h * 3600 + m * 60 + s;
        end
`ifdef RTC_DATE_EN
        else begin
          if (sh == 2'd0) dy = ((dy - 1 + d + dim(mon)) % dim(mon)) + 1;
          else if (sh == 2'd1) begin
            mon = ((mon - 1 + d + 12) % 12) + 1;
            if (dy > dim(mon)) dy = dim(mon);
          end
        end
`endif
      end
    end else begin
      phase = phase + 1;
      if (phase == FREQ) begin
        phase = 0;
        tod = tod + 1;
        if (tod == 86400) begin
          tod = 0;
          dy = dy + 1;
          if (dy > dim(mon)) begin
            dy = 1;
            mon = (mon % 12) + 1;
          end
        end
      end
      etick = (phase == FREQ - 1);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.tick = etick;
    e.h = tod / 3600; e.m = (tod / 60) % 60; e.s = tod % 60;
    e.mo = mon; e.dy = dy;
    return e;
  endfunction

  // One clock of stimulus; expected post-edge state goes to the scoreboard
  task automatic cyc(input logic [1:0] md, input logic [1:0] sh, input logic dtc,
                     input logic up, input logic dn);
    @(negedge clk);
    rst_n = 1'b1;
    model = md; adjust_shif = sh; date_time_ch = dtc; key_up = up; key_down = dn;
    model_step(md, sh, dtc, up, dn);
    sbq.push_back(snapshot());
  endtask

  task automatic press(input logic [1:0] sh, input logic dtc, input logic up, input logic dn);
    cyc(2'b01, sh, dtc, up, dn);
    cyc(2'b01, sh, dtc, 1'b0, 1'b0);
  endtask

  task automatic check_now(input string tag, input int h, input int m, input int s);
    @(posedge clk);
    #2;
    chk({tag, "_hour"}, int'(hour), h);
    chk({tag, "_minute"}, int'(minute), m);
    chk({tag, "_second"}, int'(second), s);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tick"}, int'(tick_1hz), 0);
    chk({tag, "_hour"}, int'(hour), 0);
    chk({tag, "_minute"}, int'(minute), 0);
    chk({tag, "_second"}, int'(second), 0);
`ifdef RTC_DATE_EN
    chk({tag, "_month"}, int'(month), 1);
    chk({tag, "_day"}, int'(day), 1);
`endif
  endtask

  // Asynchronous reset asserted between edges, then held for two cycles
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    repeat (2) begin
      @(negedge clk);
      sbq.push_back(snapshot());
    end
  endtask

  task automatic set_time(input int th, input int tm, input int ts);
    for (int i = 0; i < 24 && (tod / 3600) != th; i++) press(2'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && ((tod / 60) % 60) != tm; i++) press(2'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 60 && (tod % 60) != ts; i++) press(2'd0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("tick_1hz", int'(tick_1hz), int'(e.tick));
      chk("hour", int'(hour), e.h);
      chk("minute", int'(minute), e.m);
      chk("second", int'(second), e.s);
`ifdef RTC_DATE_EN
      chk("month", int'(month), e.mo);
      chk("day", int'(day), e.dy);
`endif
    end
  end

  initial begin
    logic [1:0] md;
    #3;
    check_reset_values("por");
    model_reset();

    // Free run with keys toggling: keys must be ignored outside adjust
    for (int i = 0; i < 600; i++)
      cyc(2'b00, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_now("run600", 0, 1, 0);

    // Hour decrement wraps 0 -> 23, then 100 frozen cycles
    press(2'd2, 1'b0, 1'b0, 1'b1);
    check_now("hour_wrap", 23, 1, 0);
    for (int i = 0; i < 100; i++) cyc(2'b01, 2'd3, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Preload 23:59:59 (and 12/31 with calendar)
    press(2'd1, 1'b0, 1'b0, 1'b1);
    press(2'd1, 1'b0, 1'b0, 1'b1);
    press(2'd0, 1'b0, 1'b0, 1'b1);
    press(2'd1, 1'b1, 1'b0, 1'b1);
    press(2'd0, 1'b1, 1'b0, 1'b1);
    check_now("preload", 23, 59, 59);
    for (int i = 0; i < FREQ; i++) cyc(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    check_now("midnight", 0, 0, 0);
`ifdef RTC_DATE_EN
    chk("newyear_month", int'(month), 1);
    chk("newyear_day", int'(day), 1);

    // Jan 31 -> Feb clamps day to 28
    press(2'd0, 1'b1, 1'b0, 1'b1);
    press(2'd1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("clamp_month", int'(month), 2);
    chk("clamp_day", int'(day), 28);
`endif

    // Second wrap without carry, and up+down cancelling
    press(2'd0, 1'b0, 1'b0, 1'b1);
    press(2'd0, 1'b0, 1'b1, 1'b0);
    check_now("sec_wrap", 0, 0, 0);
    press(2'd0, 1'b0, 1'b1, 1'b1);
    check_now("up_down", 0, 0, 0);

    // Randomised mix of modes, fields and key pulses
    md = 2'b00;
    for (int i = 0; i < 1500; i++) begin
      if (i % 25 == 0) md = 2'($urandom_range(0, 3));
      cyc(md, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    // Mid-count reset at 12:34:56, then restart from prescaler 0
    set_time(12, 34, 56);
    for (int i = 0; i < 5; i++) cyc(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3 * FREQ; i++) cyc(2'b00, 2'd0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
